game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Brief    : Menu/play/over sequencer for the wall game.
//            Paces wall shifts and tracks the best score.
// Revision : 1.0
// ============================================================================
module game_sequencer (
    input  logic        Clk,
    input  logic        Reset_h,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  level_sel,
    input  logic        collision,
    input  logic [12:0] Score,
    output logic [2:0]  State,
    output logic        move_walls,
    output logic        kb_reset,
    output logic        paused,
    output logic [12:0] hi_score
);

    typedef enum logic [2:0] {
        ST_MENU   = 3'd0,
        ST_EASY   = 3'd1,
        ST_MEDIUM = 3'd2,
        ST_HARD   = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        move_q, move_d;
    logic        kbr_q, kbr_d;
    logic        paused_q, paused_d;
    logic [12:0] hi_q, hi_d;

    logic [2:0]  w_base;
    logic [2:0]  w_period;
    logic [2:0]  w_limit;

    // Wall period in frames, shortened once the score reaches 256.
    always_comb begin
        case (state_q)
            ST_EASY:   w_base = 3'd4;
            ST_MEDIUM: w_base = 3'd3;
            default:   w_base = 3'd2;
        endcase
        w_period = ((Score >= 13'd256) && (w_base > 3'd1)) ? (w_base - 3'd1) : w_base;
        w_limit  = w_period - 3'd1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        move_d   = 1'b0;
        kbr_d    = 1'b0;
        paused_d = paused_q;
        hi_d     = hi_q;
        case (state_q)
            ST_MENU: begin
                paused_d = 1'b0;
                if (start && (level_sel != 2'd0)) begin
                    state_d = state_t'({1'b0, level_sel});
                    kbr_d   = 1'b1;
                    cnt_d   = 3'd0;
                end
            end
            ST_EASY, ST_MEDIUM, ST_HARD: begin
                // Collision beats pause, which beats frame counting.
                if (!paused_q && frame_tick && collision) begin
                    state_d  = ST_OVER;
                    paused_d = 1'b0;
                    if (Score > hi_q) begin
                        hi_d = Score;
                    end
                end else if (pause) begin
                    paused_d = ~paused_q;
                end else if (!paused_q && frame_tick) begin
                    if (cnt_q >= w_limit) begin
                        cnt_d  = 3'd0;
                        move_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_OVER: begin
                paused_d = 1'b0;
                if (start) begin
                    state_d = ST_MENU;
                    kbr_d   = 1'b1;
                end
            end
            default: begin
                state_d  = ST_MENU;
                paused_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q  <= ST_MENU;
            cnt_q    <= 3'd0;
            move_q   <= 1'b0;
            kbr_q    <= 1'b0;
            paused_q <= 1'b0;
            hi_q     <= 13'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            move_q   <= move_d;
            kbr_q    <= kbr_d;
            paused_q <= paused_d;
            hi_q     <= hi_d;
        end
    end

    assign State      = state_q;
    assign move_walls = move_q;
    assign kb_reset   = kbr_q;
    assign paused     = paused_q;
    assign hi_score   = hi_q;

endmodule
`default_nettype wire
